// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Multi-cycle shift-add signed/unsigned multiplier, STEP bits per cycle
// Revision : 1.0
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int c_iters = WIDTH / STEP;
  localparam int c_cw    = $clog2(c_iters + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_cw-1:0]      r_cnt;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_partial;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is exact as unsigned.
  assign w_a_neg = is_signed & multiplicand[WIDTH-1];
  assign w_b_neg = is_signed & multiplier[WIDTH-1];
  assign w_a_mag = w_a_neg ? -multiplicand : multiplicand;
  assign w_b_mag = w_b_neg ? -multiplier   : multiplier;

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (r_mplier[j]) begin
        w_partial = w_partial + (r_mcand << j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_RUN : S_IDLE;
      S_RUN:          if (r_cnt == c_cw'(1)) w_next = S_FIX;
      S_FIX:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= c_cw'(c_iters);
          end
        end
        S_RUN: begin
          r_acc    <= r_acc + w_partial;
          r_mcand  <= r_mcand << STEP;
          r_mplier <= r_mplier >> STEP;
          r_cnt    <= r_cnt - c_cw'(1);
        end
        S_FIX: begin
          r_product <= r_neg ? -r_acc : r_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state == S_RUN) || (r_state == S_FIX);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Directed and swept checks of seq_multiplier at STEP = 1, 2, 4, 8
// Revision : 1.0
// ============================================================================
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [63:0] prod_v [4];

  always #5 clk = ~clk;

  // Index i instantiates STEP = 2**i, so latencies are 33, 17, 9, 5.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      seq_multiplier #(.WIDTH(32), .STEP(1 << gi)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy_v[gi]),
        .done         (done_v[gi]),
        .product      (prod_v[gi])
      );
    end
  endgenerate

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lat [4];
  int          bcnt;
  int          dcnt;
  logic [63:0] early;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Accept one operation, scramble the inputs, then wait (bounded) until every DUT has pulsed done.
  // inj_at >= 0 raises start again with other operands at that many cycles after acceptance.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, input int inj_at);
    int t;
    mcand     = a;
    mplier    = b;
    is_signed = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    mcand     = $urandom;
    mplier    = $urandom;
    is_signed = ~s;
    for (int i = 0; i < 4; i++) lat[i] = -1;
    bcnt  = 0;
    early = '0;
    t     = 0;
    while (t < 200) begin
      for (int i = 0; i < 4; i++) begin
        if (done_v[i] && lat[i] < 0) lat[i] = t;
      end
      if (busy_v[0]) bcnt++;
      if (t == 1) early = prod_v[0];
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0 && lat[3] >= 0) break;
      if (t == inj_at) begin
        mcand     = 32'd3;
        mplier    = 32'd5;
        is_signed = 1'b1;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      t++;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] exp;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    mcand     = '0;
    mplier    = '0;
    repeat (3) tick();
    check("reset_busy", {60'd0, busy_v}, 64'd0);
    check("reset_done", {60'd0, done_v}, 64'd0);
    for (int i = 0; i < 4; i++) check($sformatf("reset_product[%0d]", i), prod_v[i], 64'd0);
    rst_n = 1'b1;
    tick();

    run(32'd7, 32'd6, 1'b0, -1);
    check("u7x6_latency",     64'(lat[0]), 64'd33);
    check("u7x6_busy_cycles", 64'(bcnt),   64'd33);
    check("u7x6_product",     prod_v[0],   64'd42);
    check("u7x6_step2_lat",   64'(lat[1]), 64'd17);
    check("u7x6_step4_lat",   64'(lat[2]), 64'd9);
    check("u7x6_step8_lat",   64'(lat[3]), 64'd5);
    tick();
    check("done_one_cycle",   {63'd0, done_v[0]}, 64'd0);
    check("product_idle_hold", prod_v[0], 64'd42);

    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    check("u_max_sq", prod_v[0], 64'hFFFF_FFFE_0000_0001);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1);
    check("s_m1xm1",       prod_v[0], 64'd1);
    check("s_m1xm1_step8", prod_v[3], 64'd1);
    run(32'hFFFF_FFFD, 32'd5, 1'b1, -1);
    check("s_m3x5",       prod_v[0], 64'hFFFF_FFFF_FFFF_FFF1);
    check("s_m3x5_step2", prod_v[1], 64'hFFFF_FFFF_FFFF_FFF1);
    run(32'h8000_0000, 32'h8000_0000, 1'b1, -1);
    check("s_min_sq", prod_v[0], 64'h4000_0000_0000_0000);
    run(32'h8000_0000, 32'd1, 1'b1, -1);
    check("s_min_x1", prod_v[0], 64'hFFFF_FFFF_8000_0000);
    run(32'd0, 32'hFFFF_FFFB, 1'b1, -1);
    check("s_0xm5", prod_v[0], 64'd0);
    run(32'h8000_0000, 32'd2, 1'b0, -1);
    check("u_2p31x2", prod_v[0], 64'h0000_0001_0000_0000);

    run(32'd100, 32'd200, 1'b0, 10);
    check("midrun_start_ignored", prod_v[0],   64'd20000);
    check("midrun_latency",       64'(lat[0]), 64'd33);
    run(32'd1000, 32'd1000, 1'b0, -1);
    check("b2b_product_held", early,        64'd20000);
    check("b2b_latency",      64'(lat[0]),  64'd33);
    check("b2b_product",      prod_v[0],    64'd1000000);

    mcand     = 32'd123;
    mplier    = 32'd456;
    is_signed = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy",    {60'd0, busy_v}, 64'd0);
    check("async_rst_done",    {60'd0, done_v}, 64'd0);
    check("async_rst_product", prod_v[0],       64'd0);
    #2 rst_n = 1'b1;
    tick();
    dcnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (done_v != 4'd0) dcnt++;
      tick();
    end
    check("no_done_after_reset", 64'(dcnt), 64'd0);
    check("product_zero_after_reset", prod_v[0], 64'd0);

    run(32'd12345, 32'd6789, 1'b0, -1);
    check("step4_product", prod_v[2],   64'd83810205);
    check("step4_latency", 64'(lat[2]), 64'd9);
    check("step1_product", prod_v[0],   64'd83810205);
    check("step1_latency", 64'(lat[0]), 64'd33);

    for (int v = 0; v < 1000; v++) begin
      ra  = pick();
      rb  = pick();
      rs  = 1'($urandom_range(0, 1));
      exp = ref_mul(ra, rb, rs);
      run(ra, rb, rs, -1);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sweep%0d_step%0d a=%h b=%h s=%0d", v, 1 << i, ra, rb, rs), prod_v[i], exp);
        check($sformatf("sweep%0d_step%0d_lat", v, 1 << i), 64'(lat[i]), 64'((32 >> i) + 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
